// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types; the instruction-queue entry travels fetch -> decode.
package rv32i_types;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        br_pred;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode; registered full back-pressure,
// single-cycle flush, no enqueue-to-dequeue bypass.
module inst_queue
  import rv32i_types::*;
#(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             enq_valid,
  input  logic [31:0]      enq_inst,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_pc_next,
  input  logic             enq_br_pred,
  output logic             full_sig,
  input  logic             deq_ready,
  output logic             deq_valid,
  output logic [31:0]      deq_inst,
  output logic [31:0]      deq_pc,
  output logic [31:0]      deq_pc_next,
  output logic             deq_br_pred,
  output logic [IDX_W:0]   count
);

  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);

  iq_entry_t        mem_q [DEPTH];
  iq_entry_t        enq_ent, head_ent;
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             enq_fire, deq_fire;

  // Status comes only from registered count, keeping deq_ready off the fetch PC path.
  assign full_sig  = (count_q == FULL_CNT);
  assign deq_valid = (count_q != '0);
  assign count     = count_q;

  assign enq_fire = enq_valid && !full_sig && !flush;
  assign deq_fire = deq_valid && deq_ready && !flush;

  assign enq_ent = '{inst: enq_inst, pc: enq_pc, pc_next: enq_pc_next, br_pred: enq_br_pred};

  always_comb begin
    head_ent = '0;
    if (deq_valid) head_ent = mem_q[head_q];
  end

  assign deq_inst    = head_ent.inst;
  assign deq_pc      = head_ent.pc;
  assign deq_pc_next = head_ent.pc_next;
  assign deq_br_pred = head_ent.br_pred;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PTR_ONE;
      if (deq_fire) head_d = head_q + PTR_ONE;
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry data is don't-care outside [head, tail), so storage carries no reset.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[tail_q] <= enq_ent;
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= FULL_CNT);
  a_ptr_count:   assert property (@(posedge clk) disable iff (!rst_n)
                   (tail_q - head_q) == count_q[IDX_W-1:0]);
  a_no_enq_full: assert property (@(posedge clk) disable iff (!rst_n) full_sig |-> !enq_fire);

endmodule

// File: tb/tb_inst_queue.sv
// Randomized + directed bench for inst_queue against a queue-based reference model.
module tb_inst_queue;
  import rv32i_types::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic [31:0] enq_inst = '0, enq_pc = '0, enq_pc_next = '0;
  logic        enq_br_pred = 1'b0;
  logic        full_sig;
  logic        deq_ready = 1'b0;
  logic        deq_valid;
  logic [31:0] deq_inst, deq_pc, deq_pc_next;
  logic        deq_br_pred;
  logic [3:0]  count;

  int n_chk = 0;
  int n_pass = 0;

  iq_entry_t mq[$];

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_inst(enq_inst), .enq_pc(enq_pc),
    .enq_pc_next(enq_pc_next), .enq_br_pred(enq_br_pred),
    .full_sig(full_sig), .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_inst(deq_inst), .deq_pc(deq_pc), .deq_pc_next(deq_pc_next),
    .deq_br_pred(deq_br_pred), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    else n_pass++;
  endtask

  // Reference model: an ordered list of accepted entries, updated with each clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mq.delete();
    else if (flush) mq.delete();
    else begin
      automatic bit ef = enq_valid && (mq.size() < DEPTH);
      automatic bit df = deq_ready && (mq.size() > 0);
      if (df) void'(mq.pop_front());
      if (ef) mq.push_back('{inst: enq_inst, pc: enq_pc, pc_next: enq_pc_next, br_pred: enq_br_pred});
    end
  end

  always @(negedge clk) begin
    automatic iq_entry_t h = (mq.size() > 0) ? mq[0] : '0;
    check("count",     {28'b0, count},        mq.size());
    check("full",      {31'b0, full_sig},     {31'b0, mq.size() == DEPTH});
    check("deq_valid", {31'b0, deq_valid},    {31'b0, mq.size() != 0});
    check("deq_inst",  deq_inst,              h.inst);
    check("deq_pc",    deq_pc,                h.pc);
    check("deq_pcnx",  deq_pc_next,           h.pc_next);
    check("deq_brp",   {31'b0, deq_br_pred},  {31'b0, h.br_pred});
  end

  // Drive one cycle's inputs (called at posedge+1), then advance to the next posedge+1.
  task automatic cyc(input bit ev, input logic [31:0] pc, input bit dr, input bit fl);
    enq_valid   = ev;
    enq_pc      = pc;
    enq_inst    = $urandom;
    enq_pc_next = $urandom_range(1) ? pc + 32'd4 : $urandom;
    enq_br_pred = $urandom_range(1);
    deq_ready   = dr;
    flush       = fl;
    @(posedge clk); #1;
    enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
  endtask

  logic [31:0] pcv;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", {28'b0, count}, 32'd0);
    check("rst_valid", {31'b0, deq_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 32'h6000_0000 + 32'(4 * i), 1'b0, 1'b0);
      check("fill_count", {28'b0, count}, 32'(i + 1));
    end
    check("fill_full", {31'b0, full_sig}, 32'd1);
    cyc(1'b1, 32'h6000_0020, 1'b0, 1'b0);
    check("ovf_count", {28'b0, count}, 32'd8);
    check("fill_head", deq_pc, 32'h6000_0000);

    // Drain in order
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_pc", deq_pc, 32'h6000_0000 + 32'(4 * i));
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      if (i == 0) check("full_drop", {31'b0, full_sig}, 32'd0);
    end
    check("drain_valid", {31'b0, deq_valid}, 32'd0);
    check("drain_count", {28'b0, count}, 32'd0);

    // Empty + enqueue: no pass-through
    enq_valid = 1'b1; enq_pc = 32'h6000_0040; deq_ready = 1'b1;
    #1 check("empty_nopass", {31'b0, deq_valid}, 32'd0);
    @(posedge clk); #1;
    enq_valid = 1'b0; deq_ready = 1'b0;
    cyc(1'b1, 32'h6000_0044, 1'b0, 1'b0);
    cyc(1'b1, 32'h6000_0048, 1'b0, 1'b0);

    // Simultaneous enq/deq at count 3, wrapping the pointers
    pcv = 32'h6000_0050;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, pcv, 1'b1, 1'b0);
      pcv += 4;
      check("simul_count", {28'b0, count}, 32'd3);
    end

    // Full with simultaneous dequeue: enqueue refused, retry accepted
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, pcv, 1'b0, 1'b0);
      pcv += 4;
    end
    check("full8", {28'b0, count}, 32'd8);
    cyc(1'b1, 32'hDEAD_0000, 1'b1, 1'b0);
    check("fulldeq_cnt", {28'b0, count}, 32'd7);
    cyc(1'b1, 32'hDEAD_0000, 1'b0, 1'b0);
    check("retry_cnt", {28'b0, count}, 32'd8);

    // Flush at count 5 beats enq and deq
    repeat (3) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("pre_flush", {28'b0, count}, 32'd5);
    cyc(1'b1, 32'hBAD0_0000, 1'b1, 1'b1);
    check("flush_cnt", {28'b0, count}, 32'd0);
    check("flush_valid", {31'b0, deq_valid}, 32'd0);
    check("flush_full", {31'b0, full_sig}, 32'd0);
    cyc(1'b1, 32'h6000_0100, 1'b0, 1'b0);
    check("post_flush_pc", deq_pc, 32'h6000_0100);

    // Asynchronous reset between edges at count 6
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h6000_0104 + 32'(4 * i), 1'b0, 1'b0);
    check("pre_rst", {28'b0, count}, 32'd6);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", {28'b0, count}, 32'd0);
    check("arst_valid", {31'b0, deq_valid}, 32'd0);
    check("arst_full", {31'b0, full_sig}, 32'd0);
    check("arst_pc", deq_pc, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 32'h6000_0200, 1'b0, 1'b0);
    check("post_rst_pc", deq_pc, 32'h6000_0200);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(99) < 60, $urandom, $urandom_range(99) < 50, $urandom_range(99) < 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- FIFO stage directly downstream of fetch; buffers fetched instructions with their PC metadata until decode/dispatch consumes them.
- Produces the `full_sig` back-pressure that fetch uses to hold its PC.
- Emptied in one cycle on a pipeline flush (branch mispredict / ROB redirect).
- Each entry carries: instruction word, PC, predicted next PC, branch-predicted-taken flag.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥2.
- IDX_W, $clog2(DEPTH), pointer index width (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  discard all entries this cycle
- enq_valid  input  1  fetch has a valid instruction (top drives imem_resp && !fetch_stall)
- enq_inst  input  32  instruction word (imem_rdata)
- enq_pc  input  32  instruction PC (pc_prev)
- enq_pc_next  input  32  predicted next PC (pc_prev_next)
- enq_br_pred  input  1  fetch predicted taken
- full_sig  output  1  queue full; fetch must hold
- deq_ready  input  1  consumer accepts head this cycle
- deq_valid  output  1  head entry valid
- deq_inst  output  32  head instruction
- deq_pc  output  32  head PC
- deq_pc_next  output  32  head predicted next PC
- deq_br_pred  output  1  head prediction flag
- count  output  IDX_W+1  current occupancy, 0..DEPTH

Behaviour:
- Storage:
  - Circular buffer, DEPTH entries; head_ptr/tail_ptr are IDX_W bits and wrap naturally (DEPTH-1 → 0).
  - Occupancy is held in a registered counter, IDX_W+1 bits.
- Status outputs:
  - `full_sig = (count == DEPTH)`, derived from registered state only; no combinational path from deq_ready.
  - `deq_valid = (count != 0)`.
  - deq_* fields read the head entry combinationally; all deq_* data are 0 when empty.
- Enqueue (enq_fire):
  - `enq_fire = enq_valid && !full_sig && !flush`.
  - On fire: write entry at tail_ptr, tail_ptr+1.
  - An entry written in cycle N is visible on deq_* in cycle N+1; no bypass, minimum latency 1.
- Dequeue (deq_fire):
  - `deq_fire = deq_valid && deq_ready && !flush`.
  - On fire: head_ptr+1.
- Count update:
  - +1 on enq_fire only; −1 on deq_fire only; unchanged if both or neither.
- Full with simultaneous dequeue: enqueue is still refused, because full_sig is registered. Fetch sees full for that cycle and retries next cycle. This is intentional and required; it avoids a deq_ready→full_sig→imem_addr timing path.
- Empty with simultaneous enqueue: deq_valid stays 0 that cycle; no pass-through.
- Flush:
  - Synchronous; takes priority over enq and deq in the same cycle.
  - Next cycle: head_ptr = tail_ptr = 0, count = 0, deq_valid = 0.
  - Entry contents need not be cleared.
  - Enq data presented in the flush cycle is dropped.
- Reset (rst_n low, asynchronous, any time including mid-operation):
  - Pointers = 0, count = 0; full_sig = 0, deq_valid = 0, deq_* = 0.
  - Entry valid state is cleared; entry data are don't-care.
  - Operation resumes on the first rising edge after rst_n deasserts.
- Illegal / overflow cases:
  - enq_valid while full is not an error; it is silently ignored (fetch holds its PC).
  - deq_ready while empty is ignored.
  - count never exceeds DEPTH or underflows; verify with assertions.

Decomposition:
- Package rv32i_types gets `iq_entry_t`, a packed struct {inst[31:0], pc[31:0], pc_next[31:0], br_pred}.
- Storage is an array of iq_entry_t. Entry width is 97 bits.
- No sub-module; pointer/count logic and the storage array live in inst_queue.
- Instantiated in the CPU top between fetch and decode. Top connects:
  - full_sig → fetch.full_sig
  - flush shared with fetch

Test Plan:
- Fill, DEPTH=8: reset; enq 8 instrs, pc 0x60000000..0x6000001C, deq_ready=0 → count goes 1..8, full_sig=1 after 8th; 9th enq ignored; deq_pc=0x60000000.
- Drain order: from full, deq_ready=1 for 8 cycles → deq_pc steps 0x60000000,+4..0x6000001C in order; deq_valid=0 and count=0 after; full_sig drops the cycle after the first deq.
- Simultaneous: count=3, enq_valid=1 and deq_ready=1 for 10 cycles → count stays 3; pointers wrap past 7→0; output order preserved, br_pred/pc_next bits match per entry.
- Full + deq same cycle: count=8, enq_valid=1, deq_ready=1 → next cycle count=7, the enqueued word is not stored; retried enq next cycle accepted, count=8.
- Flush: count=5, flush=1 with enq_valid=1 and deq_ready=1 → next cycle count=0, deq_valid=0, full_sig=0; next enq of pc 0x60000100 appears at head one cycle later.
- Async reset mid-run: count=6, drop rst_n between clock edges → full_sig, deq_valid, count go 0 immediately without a clock edge; after release, enq/deq operate normally from pointer 0.
